bist_controller: RTL and testbench

RAM built-in self-test sequencer: a control FSM plus a pattern counter and an address counter.
- Walks every address for every data pattern, watches the external mismatch flag, and reports pass/fail.
- Sits between the clock divider (which supplies `b_clk`) and the RAM under test with its comparator. The comparator consumes `pat_idx`/`addr` and returns `b_error`.

---
 rtl/bist_pkg.sv | 14 +
 rtl/bist_if.sv | 28 ++
 rtl/bist_counter.sv | 25 ++
 rtl/bist_controller.sv | 96 +++++++++
 tb/tb_bist_controller.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/bist_pkg.sv
// Shared types and default sizing for the RAM BIST sequencer.
package bist_pkg;

  localparam int unsigned DEF_ADDR_W = 10;
  localparam int unsigned DEF_PAT_W  = 8;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_TEST = 2'd1,
    ST_PASS = 2'd2,
    ST_FAIL = 2'd3
  } bist_state_e;

endpackage

// File: rtl/bist_if.sv
// Comparator-facing signal bundle: controller is master, RAM/comparator side is slave.
interface bist_if #(
  parameter int unsigned ADDR_W = bist_pkg::DEF_ADDR_W,
  parameter int unsigned PAT_W  = bist_pkg::DEF_PAT_W
) ();

  logic              b_error;
  logic              b_tst_state;
  logic              b_tst_pass;
  logic              b_tst_fail;
  logic [PAT_W-1:0]  pat_idx;
  logic [ADDR_W-1:0] addr;
  logic [PAT_W-1:0]  fail_pat;
  logic [ADDR_W-1:0] fail_addr;

  modport master (
    input  b_error,
    output b_tst_state, b_tst_pass, b_tst_fail,
    output pat_idx, addr, fail_pat, fail_addr
  );

  modport slave (
    output b_error,
    input  b_tst_state, b_tst_pass, b_tst_fail,
    input  pat_idx, addr, fail_pat, fail_addr
  );

endinterface

// File: rtl/bist_counter.sv
// Up-counter with synchronous clear/enable and an all-ones flag.
module bist_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] q,
  output logic         last
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= q + W'(1);
    end
  end

  assign last = &q;

endmodule

// File: rtl/bist_controller.sv
// RAM BIST sequencer: walks every address for every pattern and reports pass/fail.
module bist_controller
  import bist_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned PAT_W  = DEF_PAT_W
) (
  input  logic     b_clk,
  input  logic     b_rst,
  bist_if.master   bus
);

  bist_state_e       state_q, state_d;
  logic              cnt_clr;
  logic              addr_en;
  logic              pat_en;
  logic              capture;
  logic              addr_last;
  logic              pat_last;
  logic [ADDR_W-1:0] addr_q;
  logic [PAT_W-1:0]  pat_q;
  logic [ADDR_W-1:0] fail_addr_q;
  logic [PAT_W-1:0]  fail_pat_q;

  bist_counter #(.W(ADDR_W)) u_addr_cnt (
    .clk   (b_clk),
    .rst_n (b_rst),
    .clr   (cnt_clr),
    .en    (addr_en),
    .q     (addr_q),
    .last  (addr_last)
  );

  bist_counter #(.W(PAT_W)) u_pat_cnt (
    .clk   (b_clk),
    .rst_n (b_rst),
    .clr   (cnt_clr),
    .en    (pat_en),
    .q     (pat_q),
    .last  (pat_last)
  );

  always_ff @(posedge b_clk or negedge b_rst) begin
    if (!b_rst) begin
      state_q <= ST_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  // Error beats completion; the address counter wraps on its own at all-ones.
  always_comb begin
    state_d = state_q;
    cnt_clr = 1'b0;
    addr_en = 1'b0;
    pat_en  = 1'b0;
    capture = 1'b0;
    case (state_q)
      ST_INIT: begin
        cnt_clr = 1'b1;
        state_d = ST_TEST;
      end
      ST_TEST: begin
        if (bus.b_error) begin
          capture = 1'b1;
          state_d = ST_FAIL;
        end else if (addr_last && pat_last) begin
          state_d = ST_PASS;
        end else begin
          addr_en = 1'b1;
          pat_en  = addr_last;
        end
      end
      default: state_d = state_q;
    endcase
  end

  always_ff @(posedge b_clk or negedge b_rst) begin
    if (!b_rst) begin
      fail_addr_q <= '0;
      fail_pat_q  <= '0;
    end else if (capture) begin
      fail_addr_q <= addr_q;
      fail_pat_q  <= pat_q;
    end
  end

  assign bus.b_tst_state = (state_q == ST_TEST);
  assign bus.b_tst_pass  = (state_q == ST_PASS);
  assign bus.b_tst_fail  = (state_q == ST_FAIL);
  assign bus.addr        = addr_q;
  assign bus.pat_idx     = pat_q;
  assign bus.fail_addr   = fail_addr_q;
  assign bus.fail_pat    = fail_pat_q;

endmodule

// File: tb/tb_bist_controller.sv
// Bench for bist_controller: vector table, corner-case sequences, random run vs. arithmetic model.
module tb_bist_controller;

  localparam int unsigned AW  = 2;
  localparam int unsigned PW  = 1;
  localparam int          NA  = 1 << AW;
  localparam int          TOT = 1 << (AW + PW);
  localparam int unsigned BAW = 6;
  localparam int unsigned BPW = 4;
  localparam int          BTOT = 1 << (BAW + BPW);

  logic b_clk = 1'b0;
  logic b_rst = 1'b0;

  always #5 b_clk = ~b_clk;

  bist_if #(.ADDR_W(AW), .PAT_W(PW))   bus ();
  bist_if #(.ADDR_W(BAW), .PAT_W(BPW)) bus_b ();

  bist_controller #(.ADDR_W(AW), .PAT_W(PW)) dut (
    .b_clk (b_clk),
    .b_rst (b_rst),
    .bus   (bus)
  );

  bist_controller #(.ADDR_W(BAW), .PAT_W(BPW)) dut_big (
    .b_clk (b_clk),
    .b_rst (b_rst),
    .bus   (bus_b)
  );

  assign bus_b.b_error = 1'b0;

  int checks   = 0;
  int failures = 0;

  // Model: phase 0=init 1=test 2=pass 3=fail; k = linear index of current (pat,addr).
  int m_ph, m_k, m_fp, m_fa;

  typedef struct {
    logic err;
    int   st;
    int   ps;
    int   fl;
    int   pat;
    int   adr;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_ph = 0; m_k = 0; m_fp = 0; m_fa = 0;
  endfunction

  function automatic void model_step(input logic err);
    case (m_ph)
      0: begin m_ph = 1; m_k = 0; end
      1: begin
        if (err) begin
          m_ph = 3; m_fp = m_k / NA; m_fa = m_k % NA;
        end else if (m_k == TOT - 1) begin
          m_ph = 2;
        end else begin
          m_k = m_k + 1;
        end
      end
      default: ;
    endcase
  endfunction

  task automatic compare_all(input string tag);
    check({tag, ".state"},     int'(bus.b_tst_state), int'(m_ph == 1));
    check({tag, ".pass"},      int'(bus.b_tst_pass),  int'(m_ph == 2));
    check({tag, ".fail"},      int'(bus.b_tst_fail),  int'(m_ph == 3));
    check({tag, ".pat_idx"},   int'(bus.pat_idx),     m_k / NA);
    check({tag, ".addr"},      int'(bus.addr),        m_k % NA);
    check({tag, ".fail_pat"},  int'(bus.fail_pat),    m_fp);
    check({tag, ".fail_addr"}, int'(bus.fail_addr),   m_fa);
  endtask

  task automatic step(input logic err, input string tag);
    bus.b_error = err;
    @(posedge b_clk);
    model_step(err);
    #1;
    compare_all(tag);
  endtask

  // Enter reset mid-cycle, verify immediate effect, hold, then release before the next edge.
  task automatic do_reset(input int ncyc);
    b_rst = 1'b0;
    model_reset();
    #1;
    compare_all("rst_async");
    repeat (ncyc) @(posedge b_clk);
    #1;
    compare_all("rst_hold");
    b_rst = 1'b1;
  endtask

  initial begin
    int cnt;
    bus.b_error = 1'b0;
    model_reset();

    vecs[0]  = '{1'b0, 1, 0, 0, 0, 0};
    vecs[1]  = '{1'b0, 1, 0, 0, 0, 1};
    vecs[2]  = '{1'b0, 1, 0, 0, 0, 2};
    vecs[3]  = '{1'b0, 1, 0, 0, 0, 3};
    vecs[4]  = '{1'b0, 1, 0, 0, 1, 0};
    vecs[5]  = '{1'b0, 1, 0, 0, 1, 1};
    vecs[6]  = '{1'b0, 1, 0, 0, 1, 2};
    vecs[7]  = '{1'b0, 1, 0, 0, 1, 3};
    vecs[8]  = '{1'b0, 0, 1, 0, 1, 3};
    vecs[9]  = '{1'b1, 0, 1, 0, 1, 3};
    vecs[10] = '{1'b1, 0, 1, 0, 1, 3};

    // Power-up reset held for 3 cycles; also launches the large-geometry instance.
    repeat (3) @(posedge b_clk);
    #1;
    compare_all("por");
    check("por.big_state", int'(bus_b.b_tst_state), 0);
    b_rst = 1'b1;

    cnt = 0;
    for (int i = 0; i < BTOT + 100; i++) begin
      step(1'b0, "bigrun");
      if (bus_b.b_tst_state) cnt++;
      if (bus_b.b_tst_pass) break;
    end
    check("big.test_cycles", cnt, BTOT);
    check("big.pass", int'(bus_b.b_tst_pass), 1);
    check("big.fail", int'(bus_b.b_tst_fail), 0);
    check("big.addr", int'(bus_b.addr), (1 << BAW) - 1);
    check("big.pat",  int'(bus_b.pat_idx), (1 << BPW) - 1);

    // Clean run from the vector table.
    do_reset(3);
    for (int i = 0; i < 11; i++) begin
      bus.b_error = vecs[i].err;
      @(posedge b_clk);
      model_step(vecs[i].err);
      #1;
      check($sformatf("vec%0d.state", i), int'(bus.b_tst_state), vecs[i].st);
      check($sformatf("vec%0d.pass", i),  int'(bus.b_tst_pass),  vecs[i].ps);
      check($sformatf("vec%0d.fail", i),  int'(bus.b_tst_fail),  vecs[i].fl);
      check($sformatf("vec%0d.pat", i),   int'(bus.pat_idx),     vecs[i].pat);
      check($sformatf("vec%0d.addr", i),  int'(bus.addr),        vecs[i].adr);
    end
    for (int i = 0; i < 20; i++) step(1'($urandom_range(0, 1)), "pass_hold");

    // Error at (1,2).
    do_reset(1);
    for (int i = 0; i < 7; i++) step(1'b0, "err_mid_walk");
    check("err_mid.pre_pat",  int'(bus.pat_idx), 1);
    check("err_mid.pre_addr", int'(bus.addr), 2);
    step(1'b1, "err_mid_hit");
    check("err_mid.fail",      int'(bus.b_tst_fail), 1);
    check("err_mid.state",     int'(bus.b_tst_state), 0);
    check("err_mid.fail_pat",  int'(bus.fail_pat), 1);
    check("err_mid.fail_addr", int'(bus.fail_addr), 2);
    for (int i = 0; i < 6; i++) step(1'b0, "err_mid_hold");
    check("err_mid.addr_frozen", int'(bus.addr), 2);
    check("err_mid.no_pass",     int'(bus.b_tst_pass), 0);

    // Error on the final pair (1,3) must give FAIL.
    do_reset(1);
    for (int i = 0; i < 8; i++) step(1'b0, "err_last_walk");
    step(1'b1, "err_last_hit");
    check("err_last.fail",      int'(bus.b_tst_fail), 1);
    check("err_last.pass",      int'(bus.b_tst_pass), 0);
    check("err_last.fail_pat",  int'(bus.fail_pat), 1);
    check("err_last.fail_addr", int'(bus.fail_addr), 3);

    // Reset mid-test at (0,3), then restart from (0,0).
    do_reset(1);
    for (int i = 0; i < 4; i++) step(1'b0, "rst_mid_walk");
    check("rst_mid.pre_addr", int'(bus.addr), 3);
    b_rst = 1'b0;
    model_reset();
    #2;
    check("rst_mid.state", int'(bus.b_tst_state), 0);
    check("rst_mid.addr",  int'(bus.addr), 0);
    compare_all("rst_mid");
    @(posedge b_clk);
    #1;
    b_rst = 1'b1;
    step(1'b0, "rst_mid_restart");
    check("rst_mid.restart_state", int'(bus.b_tst_state), 1);
    check("rst_mid.restart_addr",  int'(bus.addr), 0);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        do_reset(int'($urandom_range(1, 3)));
      end else begin
        step(1'($urandom_range(0, 19) == 0), "rand");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
